// File: rtl/cache_mem_bridge_pkg.sv
// cache_data_structs: shared types and constants for the cache-to-memory bridge
package cache_data_structs;
    localparam int WORD_W = 32;
    localparam int LINE_BYTES = 8;
    localparam logic [2:0] MODE_BYTE_A = 3'b011;
    localparam logic [2:0] MODE_BYTE_B = 3'b101;
    typedef enum logic [2:0] {ST_IDLE, ST_WR, ST_RD_LO, ST_RD_HI, ST_DONE} bridge_state_t;
    typedef struct packed {
        logic [WORD_W-3:0] waddr;
        logic [WORD_W-1:0] wdata;
        logic [3:0]        wstrb;
    } wb_entry_t;
endpackage

// File: rtl/cache_mem_bridge_if.sv
// cache_mem_bridge_if: cache-side fill/store ports and word-wide memory handshake
interface cache_mem_bridge_if #(parameter int WIDTH = 32);
    logic               fill_req;
    logic [WIDTH-1:0]   fill_addr;
    logic               fill_valid;
    logic [2*WIDTH-1:0] fill_data;
    logic               wr_req;
    logic [WIDTH-1:0]   wr_addr;
    logic [WIDTH-1:0]   wr_data;
    logic [2:0]         wr_mode;
    logic               wr_full;
    logic               busy;
    logic               mem_req;
    logic               mem_we;
    logic [WIDTH-1:0]   mem_addr;
    logic [WIDTH-1:0]   mem_wdata;
    logic [3:0]         mem_wstrb;
    logic               mem_ack;
    logic [WIDTH-1:0]   mem_rdata;
    modport master (
        input  fill_req, fill_addr, wr_req, wr_addr, wr_data, wr_mode, mem_ack, mem_rdata,
        output fill_valid, fill_data, wr_full, busy, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
    );
    modport slave (
        output fill_req, fill_addr, wr_req, wr_addr, wr_data, wr_mode, mem_ack, mem_rdata,
        input  fill_valid, fill_data, wr_full, busy, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
    );
endinterface

// File: rtl/cache_mem_bridge_wb_fifo.sv
// cache_wb_fifo: circular write buffer of store entries with push/pop/count
module cache_wb_fifo
    import cache_data_structs::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  wb_entry_t                din,
    output wb_entry_t                dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    wb_entry_t mem_q [DEPTH];
    logic [AW-1:0] head_q, tail_q;
    logic push_ok, pop_ok;
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign pop_ok = pop && !empty;
    // a pop in the same cycle frees the slot, so a push is taken even when full
    assign push_ok = push && (!full || pop_ok);
    assign dout = mem_q[head_q];
    always_ff @(posedge clk)
        if (push_ok) mem_q[tail_q] <= din;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            count  <= '0;
        end else begin
            if (push_ok) tail_q <= tail_q + AW'(1);
            if (pop_ok) head_q <= head_q + AW'(1);
            count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
endmodule

// File: rtl/cache_mem_bridge.sv
// cache_mem_bridge: buffers write-through stores and refills 64-bit lines from word memory
module cache_mem_bridge
    import cache_data_structs::*;
#(
    parameter int WIDTH = 32,
    parameter int WB_DEPTH = 4
) (
    input logic clk,
    input logic rst_n,
    cache_mem_bridge_if.master bus
);
    localparam int CW = $clog2(WB_DEPTH) + 1;
    bridge_state_t state_q, state_d;
    logic [WIDTH-1:0] base_q;
    logic [2*WIDTH-1:0] line_q;
    wb_entry_t wr_entry, head;
    logic pop, full, empty, byte_st;
    logic [CW-1:0] count;
    assign byte_st = bus.wr_mode == MODE_BYTE_A || bus.wr_mode == MODE_BYTE_B;
    assign wr_entry = '{
        waddr: bus.wr_addr[WIDTH-1:2],
        wdata: byte_st ? {4{bus.wr_data[7:0]}} : bus.wr_data,
        wstrb: byte_st ? 4'b0001 << bus.wr_addr[1:0] : 4'hF
    };
    assign pop = state_q == ST_WR && bus.mem_ack;
    cache_wb_fifo #(.DEPTH(WB_DEPTH)) u_fifo (
        .clk(clk), .rst_n(rst_n), .push(bus.wr_req), .pop(pop), .din(wr_entry),
        .dout(head), .full(full), .empty(empty), .count(count)
    );
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= ST_IDLE;
            base_q  <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && empty && bus.fill_req) base_q <= bus.fill_addr & ~WIDTH'(LINE_BYTES - 1);
            if (state_q == ST_RD_LO && bus.mem_ack) line_q[WIDTH-1:0] <= bus.mem_rdata;
            if (state_q == ST_RD_HI && bus.mem_ack) line_q[2*WIDTH-1:WIDTH] <= bus.mem_rdata;
        end
    // buffered stores always drain before a refill starts, keeping reads coherent
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = !empty ? ST_WR : bus.fill_req ? ST_RD_LO : ST_IDLE;
            ST_WR:    if (bus.mem_ack) state_d = (count > CW'(1) || bus.wr_req) ? ST_WR : ST_IDLE;
            ST_RD_LO: if (bus.mem_ack) state_d = ST_RD_HI;
            ST_RD_HI: if (bus.mem_ack) state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
    end
    always_comb begin
        bus.mem_req    = state_q == ST_WR || state_q == ST_RD_LO || state_q == ST_RD_HI;
        bus.mem_we     = state_q == ST_WR;
        bus.mem_addr   = state_q == ST_WR ? {head.waddr, 2'b00} :
                         state_q == ST_RD_LO ? base_q :
                         state_q == ST_RD_HI ? base_q + WIDTH'(4) : '0;
        bus.mem_wdata  = state_q == ST_WR ? head.wdata : '0;
        bus.mem_wstrb  = state_q == ST_WR ? head.wstrb : 4'h0;
        bus.fill_valid = state_q == ST_DONE;
        bus.fill_data  = line_q;
        bus.wr_full    = full;
        bus.busy       = state_q != ST_IDLE || !empty;
    end
endmodule

// File: tb/tb_cache_mem_bridge.sv
// tb_cache_mem_bridge: directed self-checking bench for cache_mem_bridge
module tb_cache_mem_bridge;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    cache_mem_bridge_if #(.WIDTH(32)) bus();
    cache_mem_bridge #(.WIDTH(32), .WB_DEPTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    logic [31:0] rmem [16];
    assign bus.mem_rdata = rmem[bus.mem_addr[5:2]];
    int n_pass = 0;
    int n_total = 0;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic push(input logic [2:0] m, input logic [31:0] a, input logic [31:0] d);
        bus.wr_req = 1'b1;
        bus.wr_mode = m;
        bus.wr_addr = a;
        bus.wr_data = d;
        tick();
        bus.wr_req = 1'b0;
    endtask
    logic [2:0]  im [4] = '{3'b010, 3'b101, 3'b000, 3'b011};
    logic [31:0] ia [4] = '{32'h200, 32'h301, 32'h407, 32'h503};
    logic [31:0] id [4] = '{32'h11111111, 32'h000000C3, 32'hDEADBEEF, 32'h0000007E};
    logic [31:0] ea [4] = '{32'h200, 32'h300, 32'h404, 32'h500};
    logic [3:0]  es [4] = '{4'hF, 4'h2, 4'hF, 4'h8};
    logic [31:0] ed [4] = '{32'h11111111, 32'hC3C3C3C3, 32'hDEADBEEF, 32'h7E7E7E7E};
    logic [32:0] elog [4] = '{{1'b1, 32'h600}, {1'b1, 32'h604}, {1'b0, 32'h608}, {1'b0, 32'h60C}};
    logic [32:0] log_q [$];
    initial begin
        bit seen, fv;
        for (int i = 0; i < 16; i++) rmem[i] = 32'h0;
        rmem[2] = 32'h22222222;
        rmem[3] = 32'h33333333;
        rmem[4] = 32'hAABBCCDD;
        rmem[5] = 32'h11223344;
        bus.fill_req = 0; bus.fill_addr = 0; bus.wr_req = 0; bus.wr_addr = 0;
        bus.wr_data = 0; bus.wr_mode = 0; bus.mem_ack = 0;
        tick(); tick();
        check("rst_mem_req", bus.mem_req, 0);
        check("rst_wr_full", bus.wr_full, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_fill_valid", bus.fill_valid, 0);
        check("rst_fill_data", bus.fill_data, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        rst_n = 1'b1;
        tick();
        // zero-wait refill: fill_valid three edges after fill_req is sampled
        bus.fill_addr = 32'h14; bus.fill_req = 1; bus.mem_ack = 1;
        tick();
        check("rf_lo_req", {bus.mem_req, bus.mem_we}, 2'b10);
        check("rf_lo_addr", bus.mem_addr, 32'h10);
        tick();
        check("rf_hi_addr", bus.mem_addr, 32'h14);
        check("rf_hi_no_valid", bus.fill_valid, 0);
        tick();
        check("rf_valid", bus.fill_valid, 1);
        check("rf_data", bus.fill_data, 64'h11223344_AABBCCDD);
        check("rf_done_no_req", bus.mem_req, 0);
        bus.fill_req = 0; bus.mem_ack = 0;
        tick();
        check("rf_pulse_end", bus.fill_valid, 0);
        check("rf_idle", bus.busy, 0);
        // byte store
        push(3'b011, 32'h102, 32'h5A);
        check("bs_busy", bus.busy, 1);
        tick();
        check("bs_req_we", {bus.mem_req, bus.mem_we}, 2'b11);
        check("bs_addr", bus.mem_addr, 32'h100);
        check("bs_strb", bus.mem_wstrb, 4'b0100);
        check("bs_data", bus.mem_wdata, 32'h5A5A5A5A);
        bus.mem_ack = 1;
        tick();
        bus.mem_ack = 0;
        check("bs_req_drop", bus.mem_req, 0);
        check("bs_idle", bus.busy, 0);
        // fill the buffer, overflow push, then slow drain
        for (int i = 0; i < 4; i++) push(im[i], ia[i], id[i]);
        check("ff_full", bus.wr_full, 1);
        push(3'b010, 32'h900, 32'h99999999);
        check("ff_still_full", bus.wr_full, 1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("ff_addr%0d", i), bus.mem_addr, ea[i]);
            check($sformatf("ff_strb%0d", i), bus.mem_wstrb, es[i]);
            check($sformatf("ff_data%0d", i), bus.mem_wdata, ed[i]);
            tick(); tick();
            check($sformatf("ff_hold%0d", i), {bus.mem_req, bus.mem_addr}, {1'b1, ea[i]});
            bus.mem_ack = 1;
            tick();
            bus.mem_ack = 0;
            if (i == 0) check("ff_full_drop", bus.wr_full, 0);
        end
        check("ff_drained", {bus.mem_req, bus.busy}, 2'b00);
        // stores pending when a refill is requested
        push(3'b010, 32'h600, 32'hA0A0A0A0);
        push(3'b010, 32'h604, 32'hB0B0B0B0);
        bus.fill_addr = 32'h60C; bus.fill_req = 1; bus.mem_ack = 1;
        seen = 0;
        for (int c = 0; c < 12 && !seen; c++) begin
            if (bus.mem_req && bus.mem_ack) log_q.push_back({bus.mem_we, bus.mem_addr});
            if (bus.fill_valid) seen = 1;
            else tick();
        end
        check("rw_fill_seen", seen, 1);
        check("rw_fill_data", bus.fill_data, 64'h33333333_22222222);
        check("rw_log_len", log_q.size(), 4);
        for (int i = 0; i < 4; i++) check($sformatf("rw_order%0d", i), i < log_q.size() ? log_q[i] : 33'h0, elog[i]);
        bus.fill_req = 0; bus.mem_ack = 0;
        tick();
        check("rw_idle", bus.busy, 0);
        // push and pop together while full
        for (int i = 0; i < 4; i++) push(3'b010, 32'h700 + 32'(4 * i), 32'hF0000000 + 32'(i));
        check("pp_full", bus.wr_full, 1);
        bus.wr_req = 1; bus.wr_mode = 3'b010; bus.wr_addr = 32'h710; bus.wr_data = 32'hF0000004;
        bus.mem_ack = 1;
        tick();
        bus.wr_req = 0;
        check("pp_still_full", bus.wr_full, 1);
        for (int i = 1; i < 5; i++) begin
            check($sformatf("pp_addr%0d", i), bus.mem_addr, 32'h700 + 32'(4 * i));
            check($sformatf("pp_data%0d", i), bus.mem_wdata, 32'hF0000000 + 32'(i));
            tick();
        end
        bus.mem_ack = 0;
        check("pp_drained", bus.busy, 0);
        // reset during the high-word read
        bus.fill_addr = 32'h10; bus.fill_req = 1; bus.mem_ack = 1;
        tick();
        check("mr_lo_addr", bus.mem_addr, 32'h10);
        tick();
        bus.mem_ack = 0;
        check("mr_hi_addr", bus.mem_addr, 32'h14);
        #2 rst_n = 1'b0;
        #1;
        check("mr_req_async", bus.mem_req, 0);
        check("mr_no_valid", bus.fill_valid, 0);
        bus.fill_req = 0;
        #3 rst_n = 1'b1;
        fv = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            fv |= bus.fill_valid;
        end
        check("mr_never_valid", fv, 0);
        check("mr_busy", {bus.busy, bus.mem_req}, 2'b00);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
